wide_ram_unpacker: RTL

- Reader side of the wide/narrow RAM path: sweeps a contiguous range of wide words out of a dual-port RAM read port.
- Splits each wide word into DEINTERLEAVE narrow sub-words and emits them on a valid/ready stream, sub-word 0 first.
- Sits between a wide accumulation RAM (e.g. correlator results) and a narrow consumer (AXI-Stream/DMA packer).
- Prefetches the next wide word so the narrow stream runs without bubbles.

---
 rtl/wide_ram_unpacker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/wide_ram_unpacker.sv
// rtl/wide_ram_unpacker.sv - sweeps wide RAM words and emits them as narrow sub-words on a valid/ready stream
// Two-word window: one word in the shift register, one prefetched or in flight.
module wide_ram_unpacker #(
  parameter int DATA_WIDTH_A = 64,
  parameter int ADDR_WIDTH_A = 7,
  parameter int DEINTERLEAVE = 2,
  parameter int RAM_LATENCY  = 1,
  parameter int DATA_WIDTH_B = DATA_WIDTH_A / DEINTERLEAVE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH_A-1:0] base_addr,
  input  logic [ADDR_WIDTH_A:0]   num_words,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_en,
  output logic [ADDR_WIDTH_A-1:0] ram_addr,
  input  logic [DATA_WIDTH_A-1:0] ram_dout,
  output logic [DATA_WIDTH_B-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast
);

  localparam int SW = (DEINTERLEAVE > 1) ? $clog2(DEINTERLEAVE) : 1;
  localparam int CW = ADDR_WIDTH_A + 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(DEINTERLEAVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ram_en_q, ram_en_d;
  logic [ADDR_WIDTH_A-1:0] ram_addr_q, ram_addr_d;
  logic [CW-1:0]           rem_q, rem_d;
  logic [CW-1:0]           out_rem_q, out_rem_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [RAM_LATENCY-1:0]  rv_q, rv_d;
  logic [DATA_WIDTH_A-1:0] sr_q, sr_d;
  logic                    sr_valid_q, sr_valid_d;
  logic [DATA_WIDTH_A-1:0] pf_q, pf_d;
  logic                    pf_valid_q, pf_valid_d;
  logic [SW-1:0]           sub_q, sub_d;
  logic                    done_q, done_d;

  logic hs, pop, last_hs, capture;

  assign hs      = sr_valid_q & m_tready;
  assign pop     = hs && (sub_q == SUB_LAST);
  assign last_hs = pop && (out_rem_q == CW'(1));
  assign capture = rv_q[RAM_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    rem_d      = rem_q;
    out_rem_d  = out_rem_q;
    done_d     = 1'b0;
    sr_d       = sr_q;
    sr_valid_d = sr_valid_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    sub_d      = sub_q;
    rv_d       = RAM_LATENCY'({rv_q, ram_en_q});

    if (pop) out_rem_d = out_rem_q - CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_RUN;
            ram_en_d   = 1'b1;
            ram_addr_d = base_addr;
            rem_d      = num_words - CW'(1);
            out_rem_d  = num_words;
          end
        end
      end
      S_RUN: begin
        // A read is only issued when a buffer slot is certain to be free on return.
        if (rem_q == '0) begin
          state_d = S_FLUSH;
        end else if (cnt_q != 2'd2 || pop) begin
          ram_en_d   = 1'b1;
          ram_addr_d = ram_addr_q + ADDR_WIDTH_A'(1);
          rem_d      = rem_q - CW'(1);
        end
      end
      S_FLUSH: begin
        if (last_hs) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // Empty sweeps arrive here without a preceding done; emit it one cycle later.
        if (!done_q) done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (hs) begin
      sr_d  = sr_q >> DATA_WIDTH_B;
      sub_d = sub_q + SW'(1);
    end
    if (pop) begin
      sr_d       = pf_valid_q ? pf_q : '0;
      sr_valid_d = pf_valid_q;
      pf_valid_d = 1'b0;
      sub_d      = '0;
    end
    if (capture) begin
      if (!sr_valid_d) begin
        sr_d       = ram_dout;
        sr_valid_d = 1'b1;
      end else begin
        pf_d       = ram_dout;
        pf_valid_d = 1'b1;
      end
    end

    cnt_d = cnt_q + {1'b0, ram_en_d} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      rem_q      <= '0;
      out_rem_q  <= '0;
      cnt_q      <= '0;
      rv_q       <= '0;
      sr_q       <= '0;
      sr_valid_q <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      sub_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      rem_q      <= rem_d;
      out_rem_q  <= out_rem_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
      sr_q       <= sr_d;
      sr_valid_q <= sr_valid_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      sub_q      <= sub_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DONE && !done_q);
  assign done     = done_q;
  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;
  assign m_tdata  = sr_q[DATA_WIDTH_B-1:0];
  assign m_tvalid = sr_valid_q;
  assign m_tlast  = sr_valid_q && (sub_q == SUB_LAST) && (out_rem_q == CW'(1));

endmodule
